// File: rtl/ov7670_config_sequencer.sv
// Walks an OV7670 register table in a ROM and feeds each {reg, value} pair to an SCCB master.
// Latency: 3 cycles per ROM entry (fetch/fetch/decode), plus the SCCB write time or the delay-marker wait.
// Backpressure: waits in ISSUE while sccb_ready is low; start is honoured only in IDLE or FINISH.
//
// Ports:
//   clk, rst        - single clock (posedge), asynchronous active-high reset
//   start           - run the configuration table from entry 0
//   rom_addr        - table index; rom_data returns {reg, value} one cycle later (registered ROM)
//   sccb_start      - one-cycle write request; sccb_reg / sccb_val carry the pair to write
//   sccb_ready      - SCCB master idle; drops when a request is taken, rises again when the write ends
//   busy / done     - sequence running / sequence finished (done sticks until next start or reset)
//
// ROM markers: 16'hFFFF ends the table, 16'hFFF0 inserts a DELAY_MS wait with no write.

module ov7670_config_sequencer #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int DELAY_MS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_val,
    input  logic        sccb_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] MARK_END   = 16'hFFFF;
    localparam logic [15:0] MARK_DELAY = 16'hFFF0;

    // The counter is loaded with N-1 and the DELAY state exits on the cycle it reads 0,
    // so the DELAY state lasts exactly N cycles.
    localparam logic [31:0] DELAY_CYCLES = 32'(CLK_FREQ / 1000 * DELAY_MS);
    localparam logic [31:0] DELAY_LOAD   = DELAY_CYCLES - 32'd1;

    typedef enum logic [3:0] {
        IDLE,
        FETCH1,
        FETCH2,
        DECODE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        DELAY,
        FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic [7:0]  sccb_reg_q, sccb_reg_d;
    logic [7:0]  sccb_val_q, sccb_val_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] dly_cnt_q, dly_cnt_d;

    logic        sccb_start_d;
    logic        advance;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rom_addr_q <= 8'd0;
            sccb_reg_q <= 8'd0;
            sccb_val_q <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dly_cnt_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            sccb_reg_q <= sccb_reg_d;
            sccb_val_q <= sccb_val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dly_cnt_q  <= dly_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        sccb_reg_d   = sccb_reg_q;
        sccb_val_d   = sccb_val_q;
        busy_d       = busy_q;
        done_d       = done_q;
        dly_cnt_d    = dly_cnt_q;
        sccb_start_d = 1'b0;
        advance      = 1'b0;

        case (state_q)
            IDLE, FINISH: begin
                if (start) begin
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    rom_addr_d = 8'd0;
                    state_d    = FETCH1;
                end
            end

            // Two cycles of slack so the registered ROM output reflects rom_addr by DECODE.
            FETCH1: state_d = FETCH2;
            FETCH2: state_d = DECODE;

            DECODE: begin
                if (rom_data == MARK_END) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end else if (rom_data == MARK_DELAY) begin
                    dly_cnt_d = DELAY_LOAD;
                    state_d   = DELAY;
                end else begin
                    sccb_reg_d = rom_data[15:8];
                    sccb_val_d = rom_data[7:0];
                    state_d    = ISSUE;
                end
            end

            // sccb_start is combinational so the pulse lands in the very cycle ready is seen high.
            ISSUE: begin
                if (sccb_ready) begin
                    sccb_start_d = 1'b1;
                    state_d      = WAIT_ACK;
                end
            end

            // Ready falling is the master's acknowledgement; ready rising again ends the write.
            WAIT_ACK: begin
                if (!sccb_ready) begin
                    state_d = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (sccb_ready) begin
                    advance = 1'b1;
                end
            end

            DELAY: begin
                if (dly_cnt_q == 32'd0) begin
                    advance = 1'b1;
                end else begin
                    dly_cnt_d = dly_cnt_q - 32'd1;
                end
            end

            default: state_d = IDLE;
        endcase

        // Step to the next entry; the last index finishes instead of wrapping back to 0.
        if (advance) begin
            if (rom_addr_q == 8'hFF) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = FINISH;
            end else begin
                rom_addr_d = rom_addr_q + 8'd1;
                state_d    = FETCH1;
            end
        end
    end

    assign rom_addr   = rom_addr_q;
    assign sccb_start = sccb_start_d;
    assign sccb_reg   = sccb_reg_q;
    assign sccb_val   = sccb_val_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
